// File: rtl/tdc_result_capture.sv
// tdc_result_capture: deserializes the sequencer's MCU bit stream into
// WORD_W-bit result words and buffers them in a small FIFO.
// Optional feature macro: TDC_CAP_TAG_EN stores the 3-bit in-burst word
// index with each word and returns it as rd_data = {tag, word}.
//
// state  | meaning
// IDLE   | no segment in progress
// SHIFT  | sel_mcu high, bits being shifted in
// CLOSE  | sel_mcu just fell; push or flag a short segment this cycle
module tdc_result_capture #(
  parameter int WORD_W = 24,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel_mcu,
  input  logic              mcu_data,
  input  logic              end_read,
  input  logic              rd_en,
`ifdef TDC_CAP_TAG_EN
  output logic [WORD_W+2:0] rd_data,
`else
  output logic [WORD_W-1:0] rd_data,
`endif
  output logic              empty,
  output logic              full,
  output logic [2:0]        word_cnt,
  output logic              burst_done,
  output logic              overflow,
  output logic              short_err
);

  localparam int AW = $clog2(DEPTH);
`ifdef TDC_CAP_TAG_EN
  localparam int DW = WORD_W + 3;
`else
  localparam int DW = WORD_W;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CLOSE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                sel_q, sel_d;
  logic [WORD_W-1:0]   sh_q, sh_d;
  logic [CNT_W-1:0]    bc_q, bc_d;
  logic [AW:0]         wr_ptr_q, wr_ptr_d;
  logic [AW:0]         rd_ptr_q, rd_ptr_d;
  logic [2:0]          word_cnt_q, word_cnt_d;
  logic                burst_done_q, burst_done_d;
  logic                overflow_q, overflow_d;
  logic                short_err_q, short_err_d;
  logic                end_pend_q, end_pend_d;
  logic [DW-1:0]       mem_q [DEPTH];

  logic                seg_fall;
  logic                closing;
  logic                seg_ok;
  logic                push_req;
  logic                push;
  logic                pop;
  logic [DW-1:0]       wr_word;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign seg_fall = sel_q && !sel_mcu;
  assign closing  = (state_q == ST_CLOSE);
  assign seg_ok   = (bc_q >= CNT_W'(WORD_W));
  assign push_req = closing && seg_ok;
  assign pop      = rd_en && !empty;
  // A full FIFO still accepts the word when the head is popped in the same cycle.
  assign push     = push_req && (!full || pop);

`ifdef TDC_CAP_TAG_EN
  assign wr_word = {word_cnt_q, sh_q};
`else
  assign wr_word = sh_q;
`endif

  // Next-state logic for the segment FSM, shifter, FIFO pointers and flags.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_mcu;
    sh_d         = sh_q;
    bc_d         = bc_q;
    wr_ptr_d     = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d     = rd_ptr_q + (AW+1)'(pop);
    word_cnt_d   = word_cnt_q;
    burst_done_d = end_read;
    overflow_d   = overflow_q | (push_req && full && !pop);
    short_err_d  = short_err_q | (closing && !seg_ok);
    // end_read seen on the fall edge is held until CLOSE so the pending
    // word still gets the old index.
    end_pend_d   = seg_fall && end_read;

    case (state_q)
      ST_IDLE:  if (sel_mcu) state_d = ST_SHIFT;
      ST_SHIFT: if (seg_fall) state_d = ST_CLOSE;
      ST_CLOSE: state_d = sel_mcu ? ST_SHIFT : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (sel_mcu) sh_d = {sh_q[WORD_W-2:0], mcu_data};

    // bc is still valid during CLOSE; it is cleared there, or restarted
    // at 1 if the next segment begins in that same cycle.
    if (closing) begin
      bc_d = sel_mcu ? CNT_W'(1) : '0;
    end else if (sel_mcu && (bc_q != '1)) begin
      bc_d = bc_q + CNT_W'(1);
    end

    if (push_req && (word_cnt_q != 3'd7)) word_cnt_d = word_cnt_q + 3'd1;
    if ((end_read && !seg_fall) || end_pend_q) word_cnt_d = 3'd0;
  end

  // Register all control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sel_q        <= 1'b0;
      sh_q         <= '0;
      bc_q         <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      word_cnt_q   <= 3'd0;
      burst_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      short_err_q  <= 1'b0;
      end_pend_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      sh_q         <= sh_d;
      bc_q         <= bc_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      word_cnt_q   <= word_cnt_d;
      burst_done_q <= burst_done_d;
      overflow_q   <= overflow_d;
      short_err_q  <= short_err_d;
      end_pend_q   <= end_pend_d;
    end
  end

  // FIFO storage; cleared on reset so rd_data reads zero when empty after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_word;
    end
  end

  assign rd_data    = mem_q[rd_ptr_q[AW-1:0]];
  assign word_cnt   = word_cnt_q;
  assign burst_done = burst_done_q;
  assign overflow   = overflow_q;
  assign short_err  = short_err_q;

endmodule

// File: tb/tb_tdc_result_capture.sv
// Testbench for tdc_result_capture: vector table, hand-written corner
// sequences and a randomized run against a queue-based reference model.
module tb_tdc_result_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel_mcu;
  logic        mcu_data;
  logic        end_read;
  logic        rd_en;
`ifdef TDC_CAP_TAG_EN
  logic [26:0] rd_data;
`else
  logic [23:0] rd_data;
`endif
  logic        empty;
  logic        full;
  logic [2:0]  word_cnt;
  logic        burst_done;
  logic        overflow;
  logic        short_err;

  int n_checks = 0;
  int n_fail   = 0;

  tdc_result_capture dut (
    .clk        (clk),
    .rst        (rst),
    .sel_mcu    (sel_mcu),
    .mcu_data   (mcu_data),
    .end_read   (end_read),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .empty      (empty),
    .full       (full),
    .word_cnt   (word_cnt),
    .burst_done (burst_done),
    .overflow   (overflow),
    .short_err  (short_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500us;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          nbits;
    logic [31:0] bits;
    bit          endr;
    bit          exp_push;
    logic [23:0] exp_word;
    logic [2:0]  exp_tag;
    bit          exp_short;
    logic [2:0]  exp_wc;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] exp_head(input logic [2:0] tag, input logic [23:0] w);
`ifdef TDC_CAP_TAG_EN
    return {37'b0, tag, w};
`else
    return {40'b0, w};
`endif
  endfunction

  task automatic do_reset();
    rst = 1'b1; sel_mcu = 1'b0; mcu_data = 1'b0; end_read = 1'b0; rd_en = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Shift n bits MSB first; the last bit is sampled at the final tick (edge N).
  task automatic shift_bits(input int n, input logic [31:0] v);
    for (int i = n - 1; i >= 0; i--) begin
      sel_mcu = 1'b1; mcu_data = v[i];
      tick();
    end
    sel_mcu = 1'b0; mcu_data = 1'b0;
  endtask

  // Edge N+1 (fall seen), then edge N+2 (push) with optional pop/end_read.
  task automatic close_seg(input bit pop, input bit endr);
    tick();
    rd_en = pop; end_read = endr;
    tick();
    rd_en = 1'b0; end_read = 1'b0;
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " rd_data"},    64'(rd_data), 64'h0);
    check({tag, " empty"},      64'(empty), 64'd1);
    check({tag, " full"},       64'(full), 64'd0);
    check({tag, " word_cnt"},   64'(word_cnt), 64'd0);
    check({tag, " burst_done"}, 64'(burst_done), 64'd0);
    check({tag, " overflow"},   64'(overflow), 64'd0);
    check({tag, " short_err"},  64'(short_err), 64'd0);
  endtask

  // Reference model state for the randomized run.
  logic [26:0] mq[$];
  logic [2:0]  m_wc;
  bit          m_ovf;
  bit          m_short;

  initial begin
    vecs[0] = '{26, 32'h01A5C3F0, 1'b0, 1'b1, 24'hA5C3F0, 3'd0, 1'b0, 3'd1};
    vecs[1] = '{24, 32'h00123456, 1'b0, 1'b1, 24'h123456, 3'd1, 1'b0, 3'd2};
    vecs[2] = '{10, 32'h000002AB, 1'b0, 1'b0, 24'h000000, 3'd0, 1'b1, 3'd2};
    vecs[3] = '{30, 32'h3F000001, 1'b0, 1'b1, 24'h000001, 3'd2, 1'b1, 3'd3};
    vecs[4] = '{25, 32'h01FFFFFF, 1'b1, 1'b1, 24'hFFFFFF, 3'd3, 1'b1, 3'd4};
    vecs[5] = '{24, 32'h00DEADBE, 1'b0, 1'b1, 24'hDEADBE, 3'd0, 1'b1, 3'd1};

    // Reset state
    do_reset();
    check_reset_state("reset");

    // Single segment with exact push latency
    shift_bits(26, 32'h01A5C3F0);
    check("lat_N empty", 64'(empty), 64'd1);
    tick();
    check("lat_N1 empty", 64'(empty), 64'd1);
    tick();
    check("lat_N2 empty", 64'(empty), 64'd0);
    check("single rd_data", 64'(rd_data), exp_head(3'd0, 24'hA5C3F0));
    check("single short_err", 64'(short_err), 64'd0);

    // Vector table, one burst, FIFO drained after every word
    do_reset();
    foreach (vecs[k]) begin
      shift_bits(vecs[k].nbits, vecs[k].bits);
      close_seg(1'b0, 1'b0);
      check($sformatf("vec%0d empty", k), 64'(empty), 64'(!vecs[k].exp_push));
      check($sformatf("vec%0d short_err", k), 64'(short_err), 64'(vecs[k].exp_short));
      check($sformatf("vec%0d word_cnt", k), 64'(word_cnt), 64'(vecs[k].exp_wc));
      if (vecs[k].exp_push) begin
        check($sformatf("vec%0d rd_data", k), 64'(rd_data),
              exp_head(vecs[k].exp_tag, vecs[k].exp_word));
        pop_one();
        check($sformatf("vec%0d drained", k), 64'(empty), 64'd1);
      end
      if (vecs[k].endr) begin
        end_read = 1'b1;
        tick();
        end_read = 1'b0;
        check($sformatf("vec%0d burst_done", k), 64'(burst_done), 64'd1);
        check($sformatf("vec%0d wc_clear", k), 64'(word_cnt), 64'd0);
        tick();
        check($sformatf("vec%0d burst_done_end", k), 64'(burst_done), 64'd0);
      end
    end

    // Full burst of five words, then end_read
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      shift_bits(26, 32'(i));
      close_seg(1'b0, 1'b0);
    end
    check("burst word_cnt", 64'(word_cnt), 64'd5);
    end_read = 1'b1;
    tick();
    end_read = 1'b0;
    check("burst burst_done", 64'(burst_done), 64'd1);
    check("burst wc_clear", 64'(word_cnt), 64'd0);
    tick();
    check("burst burst_done_once", 64'(burst_done), 64'd0);
    for (int i = 1; i <= 5; i++) begin
      check($sformatf("burst word%0d", i), 64'(rd_data), exp_head(3'(i - 1), 24'(i)));
      pop_one();
    end
    check("burst drained", 64'(empty), 64'd1);

    // Overflow: nine pushes into an eight-deep FIFO
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      shift_bits(24, 32'(i));
      close_seg(1'b0, 1'b0);
      if (i == 8) check("ovf full_at8", 64'(full), 64'd1);
      if (i == 8) check("ovf flag_at8", 64'(overflow), 64'd0);
    end
    check("ovf full", 64'(full), 64'd1);
    check("ovf overflow", 64'(overflow), 64'd1);
    check("ovf word_cnt_sat", 64'(word_cnt), 64'd7);
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("ovf word%0d", i), 64'(rd_data),
            exp_head((i - 1 > 7) ? 3'd7 : 3'(i - 1), 24'(i)));
      pop_one();
    end
    check("ovf ninth_absent", 64'(empty), 64'd1);

    // Push and pop in the same cycle while full
    do_reset();
    for (int i = 0; i < 8; i++) begin
      shift_bits(24, 32'h10 + 32'(i));
      close_seg(1'b0, 1'b0);
    end
    shift_bits(24, 32'h18);
    close_seg(1'b1, 1'b0);
    check("pp_full full", 64'(full), 64'd1);
    check("pp_full overflow", 64'(overflow), 64'd0);
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("pp_full word%0d", i), 64'(rd_data),
            exp_head((i > 7) ? 3'd7 : 3'(i), 24'h10 + 24'(i)));
      pop_one();
    end
    check("pp_full drained", 64'(empty), 64'd1);

    // Push and pop in the same cycle while empty
    do_reset();
    shift_bits(24, 32'h00ABCDEF);
    close_seg(1'b1, 1'b0);
    check("pp_empty empty", 64'(empty), 64'd0);
    check("pp_empty rd_data", 64'(rd_data), exp_head(3'd0, 24'hABCDEF));

    // Next segment rising during CLOSE
    do_reset();
    shift_bits(24, 32'h00111111);
    tick();
    shift_bits(24, 32'h00222222);
    close_seg(1'b0, 1'b0);
    check("chain word_cnt", 64'(word_cnt), 64'd2);
    check("chain short_err", 64'(short_err), 64'd0);
    check("chain first", 64'(rd_data), exp_head(3'd0, 24'h111111));
    pop_one();
    check("chain second", 64'(rd_data), exp_head(3'd1, 24'h222222));

    // end_read coincident with the fifth segment's push
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      shift_bits(26, 32'h100 + 32'(i));
      close_seg(1'b0, 1'b0);
    end
    shift_bits(26, 32'h105);
    close_seg(1'b0, 1'b1);
    check("coinc burst_done", 64'(burst_done), 64'd1);
    check("coinc word_cnt", 64'(word_cnt), 64'd0);
    for (int i = 0; i < 4; i++) pop_one();
    check("coinc fifth_tag", 64'(rd_data), exp_head(3'd4, 24'h105));
    check("coinc burst_done_once", 64'(burst_done), 64'd0);

    // Reset in the middle of a segment
    do_reset();
    shift_bits(24, 32'h00777777);
    close_seg(1'b0, 1'b0);
    shift_bits(10, 32'h3);
    close_seg(1'b0, 1'b0);
    check("midrst pre short_err", 64'(short_err), 64'd1);
    shift_bits(12, 32'hABC);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_state("midrst");
    shift_bits(24, 32'h005A5A5A);
    close_seg(1'b0, 1'b0);
    check("midrst clean rd_data", 64'(rd_data), exp_head(3'd0, 24'h5A5A5A));
    check("midrst clean word_cnt", 64'(word_cnt), 64'd1);
    check("midrst clean short_err", 64'(short_err), 64'd0);

    // Randomized segments and pops against the queue model
    do_reset();
    mq.delete();
    m_wc = 3'd0; m_ovf = 1'b0; m_short = 1'b0;
    for (int it = 0; it < 80; it++) begin
      int          n;
      logic [31:0] v;
      v = $urandom;
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 23)) : int'($urandom_range(24, 30));
      shift_bits(n, v);
      close_seg(1'b0, 1'b0);
      if (n >= 24) begin
        if (mq.size() < 8) mq.push_back({m_wc, v[23:0]});
        else m_ovf = 1'b1;
        if (m_wc != 3'd7) m_wc = m_wc + 3'd1;
      end else begin
        m_short = 1'b1;
      end
      check($sformatf("rnd%0d empty", it), 64'(empty), 64'(mq.size() == 0));
      check($sformatf("rnd%0d full", it), 64'(full), 64'(mq.size() == 8));
      check($sformatf("rnd%0d word_cnt", it), 64'(word_cnt), 64'(m_wc));
      check($sformatf("rnd%0d overflow", it), 64'(overflow), 64'(m_ovf));
      check($sformatf("rnd%0d short_err", it), 64'(short_err), 64'(m_short));
      for (int p = 0; p < int'($urandom_range(0, 1)); p++) begin
        if (mq.size() > 0)
          check($sformatf("rnd%0d head", it), 64'(rd_data), exp_head(mq[0][26:24], mq[0][23:0]));
        pop_one();
        if (mq.size() > 0) void'(mq.pop_front());
      end
      if ($urandom_range(0, 4) == 0) begin
        end_read = 1'b1;
        tick();
        end_read = 1'b0;
        m_wc = 3'd0;
        check($sformatf("rnd%0d burst_done", it), 64'(burst_done), 64'd1);
        check($sformatf("rnd%0d wc_clear", it), 64'(word_cnt), 64'd0);
      end
    end
    while (mq.size() > 0) begin
      check("rnd drain head", 64'(rd_data), exp_head(mq[0][26:24], mq[0][23:0]));
      pop_one();
      void'(mq.pop_front());
    end
    check("rnd drained", 64'(empty), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
